// File: rtl/add1024_seq.sv
// Word-serial 1024-bit adder sequencer: holds X/Y operands and Z result, and streams
// word pairs LSB-first to an external word adder that keeps its own carry.
module add1024_seq #(
    parameter int WORDS = 32,
    parameter int W     = 32
) (
    input  logic         iClk,
    input  logic         iRst_n,
    input  logic         iWrEn,
    input  logic [1:0]   iWrSel,
    input  logic [4:0]   iWrAddr,
    input  logic [W-1:0] iWrData,
    input  logic         iStart,
    output logic         oBusy,
    output logic         oDone,
    input  logic [4:0]   iRdAddr,
    output logic [W-1:0] oRdData,
    output logic         oAddEn,
    output logic [W-1:0] oAddX,
    output logic [W-1:0] oAddY,
    input  logic [W-1:0] iAddZ
);

    localparam logic [4:0] LAST_IDX = 5'(WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_state_next;
    logic [4:0]   r_idx;
    logic [4:0]   w_idx_next;
    logic [W-1:0] r_rd_data;

    logic [W-1:0] r_x_mem [WORDS];
    logic [W-1:0] r_y_mem [WORDS];
    logic [W-1:0] r_z_mem [WORDS];

    logic w_x_we;
    logic w_y_we;
    logic w_z_we;

    // Operand writes are only accepted while idle so the running sum stays consistent.
    assign w_x_we = iWrEn && (r_state == ST_IDLE) && (iWrSel == 2'd0);
    assign w_y_we = iWrEn && (r_state == ST_IDLE) && (iWrSel == 2'd1);
    assign w_z_we = (r_state == ST_RUN);

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        oBusy        = 1'b0;
        oDone        = 1'b0;
        oAddEn       = 1'b0;
        oAddX        = '0;
        oAddY        = '0;
        case (r_state)
            ST_IDLE: begin
                if (iStart) begin
                    w_state_next = ST_RUN;
                    w_idx_next   = '0;
                end
            end
            ST_RUN: begin
                oBusy  = 1'b1;
                oAddEn = 1'b1;
                oAddX  = r_x_mem[r_idx];
                oAddY  = r_y_mem[r_idx];
                // Index holds at the last word on exit rather than wrapping.
                if (r_idx == LAST_IDX) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_idx_next = r_idx + 5'd1;
                end
            end
            ST_DONE: begin
                oBusy        = 1'b1;
                oDone        = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge iClk) begin
        if (w_x_we) begin
            r_x_mem[iWrAddr] <= iWrData;
        end
        if (w_y_we) begin
            r_y_mem[iWrAddr] <= iWrData;
        end
        if (w_z_we) begin
            r_z_mem[r_idx] <= iAddZ;
        end
    end

    // Read-before-write: a word being captured this edge returns its old value.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_z_mem[iRdAddr];
        end
    end

    assign oRdData = r_rd_data;

endmodule

// File: tb/tb_add1024_seq.sv
// Self-checking bench for add1024_seq: a carry-keeping word adder model feeds iAddZ and
// results are compared against a 1024-bit arithmetic reference.
module tb_add1024_seq;

    localparam int WORDS = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        iWrEn;
    logic [1:0]  iWrSel;
    logic [4:0]  iWrAddr;
    logic [31:0] iWrData;
    logic        iStart;
    logic        oBusy;
    logic        oDone;
    logic [4:0]  iRdAddr;
    logic [31:0] oRdData;
    logic        oAddEn;
    logic [31:0] oAddX;
    logic [31:0] oAddY;
    logic [31:0] iAddZ;

    logic [31:0] mx [WORDS];
    logic [31:0] my [WORDS];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    add1024_seq #(.WORDS(WORDS), .W(32)) dut (
        .iClk    (clk),
        .iRst_n  (rst_n),
        .iWrEn   (iWrEn),
        .iWrSel  (iWrSel),
        .iWrAddr (iWrAddr),
        .iWrData (iWrData),
        .iStart  (iStart),
        .oBusy   (oBusy),
        .oDone   (oDone),
        .iRdAddr (iRdAddr),
        .oRdData (oRdData),
        .oAddEn  (oAddEn),
        .oAddX   (oAddX),
        .oAddY   (oAddY),
        .iAddZ   (iAddZ)
    );

    // Downstream word adder: carry held between words, cleared whenever oAddEn is low.
    logic        carry_q;
    logic [32:0] add_sum;
    assign add_sum = {1'b0, oAddX} + {1'b0, oAddY} + {32'd0, carry_q};
    assign iAddZ   = add_sum[31:0];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)       carry_q <= 1'b0;
        else if (!oAddEn) carry_q <= 1'b0;
        else              carry_q <= add_sum[32];
    end

    task automatic wr(input logic [1:0] sel, input int addr, input logic [31:0] d);
        iWrEn   = 1'b1;
        iWrSel  = sel;
        iWrAddr = addr[4:0];
        iWrData = d;
        @(negedge clk);
        iWrEn = 1'b0;
        if (sel == 2'd0)      mx[addr] = d;
        else if (sel == 2'd1) my[addr] = d;
    endtask

    task automatic load_random();
        for (int k = 0; k < WORDS; k++) wr(2'd0, k, $urandom);
        for (int k = 0; k < WORDS; k++) wr(2'd1, k, $urandom);
    endtask

    task automatic run_op(input bit inject, input string name);
        int cyc;
        int en_cnt;
        int xy_bad;
        int extra_done;
        int extra_busy;
        iStart = 1'b1;
        @(negedge clk);
        iStart = 1'b0;
        cyc = 1; en_cnt = 0; xy_bad = 0;
        while (!oDone && cyc < 100) begin
            if (oAddEn) begin
                en_cnt++;
                if (cyc > WORDS) xy_bad++;
                else if (oAddX !== mx[cyc-1] || oAddY !== my[cyc-1]) xy_bad++;
            end
            if (inject && (cyc == 5 || cyc == 20)) begin
                iStart = 1'b1; iWrEn = 1'b1; iWrSel = 2'd0; iWrAddr = 5'd0; iWrData = 32'hDEADBEEF;
            end else begin
                iStart = 1'b0; iWrEn = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        iStart = 1'b0; iWrEn = 1'b0;
        total++;
        if (cyc !== WORDS + 1) begin
            bad++; $display("FAIL %s latency: got %0d cycles, want %0d", name, cyc, WORDS + 1);
        end
        total++;
        if (en_cnt !== WORDS) begin
            bad++; $display("FAIL %s addEn_cycles: got %0d, want %0d", name, en_cnt, WORDS);
        end
        total++;
        if (xy_bad !== 0) begin
            bad++; $display("FAIL %s operand_words: got %0d bad words, want 0", name, xy_bad);
        end
        total++;
        if ({oBusy, oAddEn, oAddX, oAddY} !== {1'b1, 1'b0, 64'd0}) begin
            bad++; $display("FAIL %s done_outputs: busy=%b en=%b x=%h y=%h, want 1 0 0 0",
                            name, oBusy, oAddEn, oAddX, oAddY);
        end
        // A start held during DONE must not launch another operation.
        iStart = inject;
        @(negedge clk);
        iStart = 1'b0;
        extra_done = 0; extra_busy = 0;
        for (int i = 0; i < 3; i++) begin
            if (oDone) extra_done++;
            if (oBusy) extra_busy++;
            @(negedge clk);
        end
        total++;
        if (extra_done !== 0 || extra_busy !== 0) begin
            bad++; $display("FAIL %s single_done: extra done=%0d busy=%0d, want 0 0",
                            name, extra_done, extra_busy);
        end
        $display("op %s: latency=%0d addEn=%0d", name, cyc, en_cnt);
    endtask

    task automatic check_z(input string name);
        logic [1023:0] a;
        logic [1023:0] b;
        logic [1023:0] s;
        int nbad;
        for (int k = 0; k < WORDS; k++) begin
            a[k*32 +: 32] = mx[k];
            b[k*32 +: 32] = my[k];
        end
        s = a + b;
        nbad = 0;
        iRdAddr = 5'd0;
        @(negedge clk);
        for (int k = 0; k < WORDS; k++) begin
            if (k < WORDS - 1) iRdAddr = 5'(k + 1);
            total++;
            if (oRdData !== s[k*32 +: 32]) begin
                bad++; nbad++;
                $display("FAIL %s z[%0d]: got %h, want %h", name, k, oRdData, s[k*32 +: 32]);
            end
            @(negedge clk);
        end
        $display("read %s: %0d words, %0d wrong", name, WORDS, nbad);
    endtask

    task automatic check_idle_zero(input string name);
        total++;
        if ({oBusy, oDone, oAddEn, oAddX, oAddY, oRdData} !== 99'd0) begin
            bad++;
            $display("FAIL %s: busy=%b done=%b en=%b x=%h y=%h rd=%h, want all 0",
                     name, oBusy, oDone, oAddEn, oAddX, oAddY, oRdData);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_zero("reset_state");
        rst_n = 1'b1;
        @(negedge clk);
        $display("test_reset done");
    endtask

    task automatic test_carry();
        for (int k = 0; k < WORDS; k++) wr(2'd0, k, 32'hFFFF_FFFF);
        for (int k = 0; k < WORDS; k++) wr(2'd1, k, (k == 0) ? 32'd1 : 32'd0);
        run_op(1'b0, "carry");
        check_z("carry");
    endtask

    task automatic test_carry_clear();
        for (int k = 0; k < WORDS; k++) wr(2'd0, k, 32'd0);
        for (int k = 0; k < WORDS; k++) wr(2'd1, k, 32'd0);
        run_op(1'b0, "carry_clear");
        check_z("carry_clear");
    endtask

    task automatic test_pattern();
        for (int k = 0; k < WORDS; k++) wr(2'd0, k, 32'(k));
        for (int k = 0; k < WORDS; k++) wr(2'd1, k, 32'h1000_0000);
        run_op(1'b0, "pattern");
        check_z("pattern");
    endtask

    task automatic test_ignore_busy();
        load_random();
        run_op(1'b1, "ignore_busy");
        check_z("ignore_busy");
    endtask

    task automatic test_bad_sel();
        load_random();
        wr(2'd2, 3, $urandom);
        wr(2'd3, 7, $urandom);
        wr(2'd2, 0, 32'hDEADBEEF);
        run_op(1'b0, "bad_sel");
        check_z("bad_sel");
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            load_random();
            run_op(1'b0, $sformatf("random%0d", r));
            check_z($sformatf("random%0d", r));
        end
    endtask

    task automatic test_reset_midrun();
        int seen;
        load_random();
        iStart = 1'b1;
        @(negedge clk);
        iStart = 1'b0;
        repeat (9) @(negedge clk);
        total++;
        if (oAddEn !== 1'b1) begin
            bad++; $display("FAIL midrun_running: addEn=%b, want 1", oAddEn);
        end
        rst_n = 1'b0;
        #1;
        check_idle_zero("midrun_async_reset");
        seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (oDone) seen++;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (oDone || oBusy) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++; $display("FAIL midrun_no_done: got %0d done/busy cycles, want 0", seen);
        end
        run_op(1'b0, "after_abort");
        check_z("after_abort");
    endtask

    initial begin
        rst_n   = 1'b0;
        iWrEn   = 1'b0;
        iWrSel  = 2'd0;
        iWrAddr = 5'd0;
        iWrData = 32'd0;
        iStart  = 1'b0;
        iRdAddr = 5'd0;
        test_reset();
        test_carry();
        test_carry_clear();
        test_pattern();
        test_ignore_busy();
        test_bad_sel();
        test_random();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
